// File: rtl/fpu_ss_mem_meta_buffer.sv
// Metadata FIFO ({rd, we, id}) between the FPU subsystem controller and the X-interface memory channel.
// Optional same-cycle bypass when empty: define FPU_SS_MEM_BUF_FALLTHROUGH_EN.
module fpu_ss_mem_meta_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ID_WIDTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_valid_i,
  output logic                       push_ready_o,
  input  logic [4:0]                 push_rd_i,
  input  logic                       push_we_i,
  input  logic [ID_WIDTH-1:0]        push_id_i,
  output logic                       pop_valid_o,
  input  logic                       pop_ready_i,
  output logic [4:0]                 pop_rd_o,
  output logic                       pop_we_o,
  output logic [ID_WIDTH-1:0]        pop_id_o,
  input  logic [ID_WIDTH-1:0]        result_id_i,
  output logic [$clog2(DEPTH+1)-1:0] usage_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       err_id_o,
  output logic                       err_underflow_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [4:0]          rd_mem_q [DEPTH];
  logic [4:0]          rd_mem_d [DEPTH];
  logic                we_mem_q [DEPTH];
  logic                we_mem_d [DEPTH];
  logic [ID_WIDTH-1:0] id_mem_q [DEPTH];
  logic [ID_WIDTH-1:0] id_mem_d [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_id_q, err_id_d;
  logic             err_underflow_q, err_underflow_d;

  logic push_hs, pop_hs, bypass, store, head_pop;

  assign empty_o         = (count_q == '0);
  assign full_o          = (count_q == CNT_FULL);
  assign usage_o         = count_q;
  assign push_ready_o    = ~full_o;
  assign err_id_o        = err_id_q;
  assign err_underflow_o = err_underflow_q;

`ifdef FPU_SS_MEM_BUF_FALLTHROUGH_EN
  // When empty the incoming entry is presented as head in the same cycle.
  always_comb begin
    pop_valid_o = 1'b1;
    pop_rd_o    = rd_mem_q[rd_ptr_q];
    pop_we_o    = we_mem_q[rd_ptr_q];
    pop_id_o    = id_mem_q[rd_ptr_q];
    if (empty_o) begin
      pop_valid_o = push_valid_i;
      pop_rd_o    = push_rd_i;
      pop_we_o    = push_we_i;
      pop_id_o    = push_id_i;
    end
  end
  assign bypass = empty_o & push_valid_i & pop_ready_i;
`else
  assign pop_valid_o = ~empty_o;
  assign pop_rd_o    = rd_mem_q[rd_ptr_q];
  assign pop_we_o    = we_mem_q[rd_ptr_q];
  assign pop_id_o    = id_mem_q[rd_ptr_q];
  assign bypass      = 1'b0;
`endif

  assign push_hs  = push_valid_i & push_ready_o;
  assign pop_hs   = pop_valid_o & pop_ready_i;
  assign store    = push_hs & ~bypass;
  assign head_pop = pop_hs & ~empty_o;

  always_comb begin
    rd_mem_d        = rd_mem_q;
    we_mem_d        = we_mem_q;
    id_mem_d        = id_mem_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    err_id_d        = err_id_q;
    err_underflow_d = err_underflow_q;

    if (flush_i) begin
      wr_ptr_d        = '0;
      rd_ptr_d        = '0;
      count_d         = '0;
      err_id_d        = 1'b0;
      err_underflow_d = 1'b0;
    end else begin
      if (store) begin
        rd_mem_d[wr_ptr_q] = push_rd_i;
        we_mem_d[wr_ptr_q] = push_we_i;
        id_mem_d[wr_ptr_q] = push_id_i;
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (head_pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({store, head_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (pop_hs && (result_id_i != pop_id_o)) begin
        err_id_d = 1'b1;
      end
      if (pop_ready_i && !pop_valid_o) begin
        err_underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rd_mem_q[i] <= '0;
        we_mem_q[i] <= 1'b0;
        id_mem_q[i] <= '0;
      end
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      err_id_q        <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      rd_mem_q        <= rd_mem_d;
      we_mem_q        <= we_mem_d;
      id_mem_q        <= id_mem_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      err_id_q        <= err_id_d;
      err_underflow_q <= err_underflow_d;
    end
  end

endmodule

// File: tb/tb_fpu_ss_mem_meta_buffer.sv
// Directed bench for fpu_ss_mem_meta_buffer: a DEPTH=4 instance plus a DEPTH=3 instance for pointer wrap.
module tb_fpu_ss_mem_meta_buffer;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  logic       flush, push_valid, push_ready, push_we, pop_valid, pop_ready, pop_we;
  logic [4:0] push_rd, pop_rd;
  logic [3:0] push_id, pop_id, result_id;
  logic [2:0] usage;
  logic       full, empty, err_id, err_underflow;

  logic       b_flush, b_push_valid, b_push_ready, b_push_we, b_pop_valid, b_pop_ready, b_pop_we;
  logic [4:0] b_push_rd, b_pop_rd;
  logic [3:0] b_push_id, b_pop_id, b_result_id;
  logic [1:0] b_usage;
  logic       b_full, b_empty, b_err_id, b_err_underflow;

  int passes = 0;
  int total  = 0;

  fpu_ss_mem_meta_buffer #(.DEPTH(4), .ID_WIDTH(4)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
    .push_valid_i(push_valid), .push_ready_o(push_ready), .push_rd_i(push_rd),
    .push_we_i(push_we), .push_id_i(push_id),
    .pop_valid_o(pop_valid), .pop_ready_i(pop_ready), .pop_rd_o(pop_rd),
    .pop_we_o(pop_we), .pop_id_o(pop_id), .result_id_i(result_id),
    .usage_o(usage), .full_o(full), .empty_o(empty),
    .err_id_o(err_id), .err_underflow_o(err_underflow)
  );

  fpu_ss_mem_meta_buffer #(.DEPTH(3), .ID_WIDTH(4)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(b_flush),
    .push_valid_i(b_push_valid), .push_ready_o(b_push_ready), .push_rd_i(b_push_rd),
    .push_we_i(b_push_we), .push_id_i(b_push_id),
    .pop_valid_o(b_pop_valid), .pop_ready_i(b_pop_ready), .pop_rd_o(b_pop_rd),
    .pop_we_o(b_pop_we), .pop_id_o(b_pop_id), .result_id_i(b_result_id),
    .usage_o(b_usage), .full_o(b_full), .empty_o(b_empty),
    .err_id_o(b_err_id), .err_underflow_o(b_err_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    flush = 0; push_valid = 0; push_rd = '0; push_we = 0; push_id = '0; pop_ready = 0; result_id = '0;
    b_flush = 0; b_push_valid = 0; b_push_rd = '0; b_push_we = 0; b_push_id = '0;
    b_pop_ready = 0; b_result_id = '0;
    #1;
    chk("rst_push_ready", push_ready, 1);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_pop_rd", pop_rd, 0);
    chk("rst_pop_we", pop_we, 0);
    chk("rst_pop_id", pop_id, 0);
    chk("rst_usage", usage, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_err_id", err_id, 0);
    chk("rst_err_uf", err_underflow, 0);
    chk("rst3_usage", b_usage, 0);
    chk("rst3_empty", b_empty, 1);
    step();
    rst_ni = 1'b1;
    step();

    // single push, 1-cycle latency, then pop with matching id
    push_valid = 1; push_rd = 5'd3; push_we = 1; push_id = 4'd5;
    step();
    push_valid = 0;
    chk("p1_pop_valid", pop_valid, 1);
    chk("p1_pop_rd", pop_rd, 3);
    chk("p1_pop_we", pop_we, 1);
    chk("p1_pop_id", pop_id, 5);
    chk("p1_usage", usage, 1);
    pop_ready = 1; result_id = 4'd5;
    step();
    pop_ready = 0;
    chk("p1_pop_usage", usage, 0);
    chk("p1_pop_empty", empty, 1);
    chk("p1_pop_err_id", err_id, 0);

    // fill (pointers start at 1, so they wrap)
    for (int i = 0; i < 4; i++) begin
      push_valid = 1; push_rd = 5'(8 + i); push_we = i[0]; push_id = 4'(i);
      step();
    end
    chk("fill_full", full, 1);
    chk("fill_push_ready", push_ready, 0);
    chk("fill_usage", usage, 4);
    push_rd = 5'd20; push_we = 0; push_id = 4'd7;
    step();
    chk("ovf_usage", usage, 4);
    chk("ovf_head_id", pop_id, 0);
    chk("ovf_head_rd", pop_rd, 8);
    chk("ovf_head_we", pop_we, 0);
    chk("ovf_err_id", err_id, 0);

    // full: pop + push together, push refused
    pop_ready = 1; result_id = 4'd0;
    step();
    push_valid = 0;
    chk("fpp_usage", usage, 3);
    chk("fpp_head_id", pop_id, 1);
    chk("fpp_full", full, 0);
    chk("fpp_push_ready", push_ready, 1);

    // id mismatch: head 1, result 2
    result_id = 4'd2;
    step();
    chk("mis_err_id", err_id, 1);
    chk("mis_usage", usage, 2);
    chk("mis_head_id", pop_id, 2);
    chk("mis_head_rd", pop_rd, 10);
    step();
    chk("pop2_head_id", pop_id, 3);
    chk("pop2_head_we", pop_we, 1);
    result_id = 4'd3;
    step();
    pop_ready = 0;
    chk("drain_usage", usage, 0);
    chk("drain_empty", empty, 1);
    chk("drain_err_sticky", err_id, 1);

    // flush overrides a push in the same cycle
    flush = 1; push_valid = 1; push_id = 4'd4;
    step();
    flush = 0; push_valid = 0;
    chk("flush_err_id", err_id, 0);
    chk("flush_usage", usage, 0);
    chk("flush_empty", empty, 1);

    // underflow
    pop_ready = 1;
    step();
    pop_ready = 0;
    chk("uf_err", err_underflow, 1);
    chk("uf_usage", usage, 0);
    chk("uf_empty", empty, 1);
    step();
    chk("uf_sticky", err_underflow, 1);
    flush = 1;
    step();
    flush = 0;
    chk("uf_flush", err_underflow, 0);

`ifdef FPU_SS_MEM_BUF_FALLTHROUGH_EN
    push_valid = 1; push_rd = 5'd4; push_we = 1; push_id = 4'd9; pop_ready = 1; result_id = 4'd9;
    #1;
    chk("ft_pop_valid", pop_valid, 1);
    chk("ft_pop_id", pop_id, 9);
    chk("ft_pop_rd", pop_rd, 4);
    step();
    push_valid = 0; pop_ready = 0;
    chk("ft_usage", usage, 0);
    chk("ft_err_id", err_id, 0);
    chk("ft_err_uf", err_underflow, 0);
    push_valid = 1; push_id = 4'd6;
    #1;
    chk("ft_store_valid", pop_valid, 1);
    step();
    push_valid = 0;
    chk("ft_store_usage", usage, 1);
    chk("ft_store_id", pop_id, 6);
`else
    push_valid = 1; push_rd = 5'd4; push_we = 1; push_id = 4'd9; pop_ready = 1; result_id = 4'd9;
    #1;
    chk("nb_pop_valid", pop_valid, 0);
    step();
    push_valid = 0; pop_ready = 0;
    chk("nb_usage", usage, 1);
    chk("nb_err_uf", err_underflow, 1);
    chk("nb_head_id", pop_id, 9);
`endif
    flush = 1;
    step();
    flush = 0;

    // asynchronous reset mid-operation
    push_valid = 1; push_rd = 5'd1; push_id = 4'd11;
    step();
    push_id = 4'd12;
    step();
    push_valid = 0;
    chk("ar_pre_usage", usage, 2);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("ar_usage", usage, 0);
    chk("ar_empty", empty, 1);
    chk("ar_pop_valid", pop_valid, 0);
    chk("ar_pop_id", pop_id, 0);
    chk("ar_push_ready", push_ready, 1);
    step();
    rst_ni = 1'b1;
    step();

    // DEPTH=3: ten push/pop pairs, one entry in flight
    for (int k = 0; k <= 10; k++) begin
      b_push_valid = (k < 10);
      b_push_id    = 4'(k);
      b_push_rd    = 5'(k + 1);
      b_pop_ready  = (k > 0);
      b_result_id  = 4'(k - 1);
      if (k > 0) begin
        chk("d3_head_id", b_pop_id, k - 1);
        chk("d3_head_rd", b_pop_rd, k);
      end
      step();
      chk("d3_usage", b_usage, (k < 10) ? 1 : 0);
    end
    b_push_valid = 0; b_pop_ready = 0;
    chk("d3_err_id", b_err_id, 0);
    chk("d3_err_uf", b_err_underflow, 0);
    chk("d3_empty", b_empty, 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
